// File: rtl/pipe_elastic_reg_pkg.sv
// Shared pipeline types: per-stage payload structs and elastic-register defaults.
// Stage boundaries pass $bits(<stage>_t) as WIDTH and cast the flat payload back.
package pipe_elastic_reg_pkg;

    localparam int PIPE_DEPTH_DEFAULT = 2;
    localparam int PIPE_ZERO_BUBBLE   = 1;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        wb_sel_e     wb_sel;
    } decode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic        mem_rd;
        logic        mem_wr;
        wb_sel_e     wb_sel;
    } execute_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        wb_sel_e     wb_sel;
    } memory_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
    } writeback_t;

    // Storage depth must be a power of two so the pointers wrap naturally.
    function automatic logic is_pow2_depth(input int depth);
        is_pow2_depth = (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipe_elastic_reg_chk.sv
// Simulation-only consistency checks on the elastic register's occupancy state.
module pipe_elastic_reg_chk
    import pipe_elastic_reg_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic [$clog2(DEPTH)-1:0] wr_ptr,
    input logic [$clog2(DEPTH)-1:0] rd_ptr,
    input logic [$clog2(DEPTH):0]   count
);

    localparam int                 AW       = $clog2(DEPTH);
    localparam logic [AW:0]        FULL     = (AW + 1)'(DEPTH);
    localparam logic               DEPTH_OK = is_pow2_depth(DEPTH);

    a_depth_pow2: assert property (@(posedge clk) DEPTH_OK);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= FULL);

    // Equal pointers are ambiguous: occupancy must then be either empty or full.
    a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        (count[AW-1:0] == AW'(wr_ptr - rd_ptr)) &&
        ((wr_ptr != rd_ptr) || (count == {(AW + 1){1'b0}}) || (count == FULL)));

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: valid/ready handshake, DEPTH-entry skid storage,
// synchronous flush, optional zeroed bubbles. No combinational in->out path.
module pipe_elastic_reg
    import pipe_elastic_reg_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = PIPE_DEPTH_DEFAULT,
    parameter int ZERO_BUBBLE = PIPE_ZERO_BUBBLE
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             in_ready_s, out_valid_s, push_s, pop_s;

    assign in_ready_s  = (count_q != FULL);
    assign out_valid_s = (count_q != {(AW + 1){1'b0}});
    assign push_s      = in_valid & in_ready_s;
    assign pop_s       = out_valid_s & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_q;

    // Next-state for pointers and occupancy; flush wins over any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy and pointer state, cleared asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents deliberately survive reset and flush.
    always_ff @(posedge CLK) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Head presentation; bubbles read as zero when ZERO_BUBBLE is set.
    always_comb begin
        out_data = mem_q[rd_ptr_q];
        if (out_valid_s || (ZERO_BUBBLE == 0)) begin
            out_data = mem_q[rd_ptr_q];
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

    pipe_elastic_reg_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk    (CLK),
        .rst_n  (nRST),
        .wr_ptr (wr_ptr_q),
        .rd_ptr (rd_ptr_q),
        .count  (count_q)
    );

endmodule

// File: doc/pipe_elastic_reg.md
Name: pipe_elastic_reg

Overview:
- Parametrised elastic pipeline register that replaces the fixed, stall-only latches between fetch/decode/execute/memory/writeback.
- Carries any stage struct as a flat payload vector of WIDTH bits.
- Provides a valid/ready handshake, DEPTH-entry skid storage, synchronous flush for branch/jump squash, and optional zeroed bubbles.
- Sits between two pipeline stages; one instance per stage boundary.

Parameters:
- WIDTH, 64: payload width in bits; instances set it to the bit width of the carried stage struct.
- DEPTH, 2: number of storage entries; power of two, ≥2. DEPTH=2 gives full throughput with no combinational ready path.
- ZERO_BUBBLE, 1: 1 = out_data is all-zero whenever out_valid=0; 0 = out_data shows the stale head entry.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream stage presents a payload
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  register can accept a payload this cycle
- out_valid  out  1  head entry is valid
- out_data  out  WIDTH  head payload
- out_ready  in  1  downstream stage consumes the head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset:
  - nRST low → immediately count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1.
  - out_data=0 when ZERO_BUBBLE=1.
  - Storage array contents are not reset.
- Reset mid-operation: all held entries are lost, with no partial transfer.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A transfer happens at the rising CLK edge where the condition is high.
- Derived outputs:
  - in_ready = (count != DEPTH). It is a function of registered state only and never depends on out_ready (no bypass).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid; otherwise 0 (ZERO_BUBBLE=1) or mem[rd_ptr] (ZERO_BUBBLE=0).
- Latency: a payload pushed at edge N is visible on out_data/out_valid after edge N (1 cycle minimum). There is no same-cycle pass-through.
- Push: mem[wr_ptr] ← in_data; wr_ptr increments modulo DEPTH (natural wrap of a $clog2(DEPTH)-bit pointer).
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: count+1.
  - pop only: count−1.
  - push & pop together: unchanged.
- Full (count=DEPTH):
  - in_ready=0, so in_valid is ignored.
  - A simultaneous pop frees the slot for the next cycle only.
- Empty (count=0): out_valid=0, so out_ready is ignored and count never underflows.
- Flush:
  - At the edge with flush=1: count←0, rd_ptr←0, wr_ptr←0.
  - Flush overrides any push or pop in the same cycle; the in_data presented that cycle is discarded.
  - in_ready stays as computed from pre-flush state; the upstream stage treats a flushed cycle as squashed.
- Stall: the upstream stage holds in_valid and in_data stable while in_ready=0. The block does not check this; the bench asserts it on the upstream side.
- Assertions (simulation only):
  - count ≤ DEPTH.
  - count equals (wr_ptr − rd_ptr) mod DEPTH, or DEPTH when the pointers are equal and the register is full.
  - DEPTH is a power of two ≥2 (elaboration check).
- Expected size: about 150 lines of RTL.

Decomposition:
- Shared types package (with the stage structs):
  - fetch/decode/execute/memory/writeback stage structs stay there.
  - Add localparams PIPE_DEPTH_DEFAULT=2 and PIPE_ZERO_BUBBLE=1.
  - Instances pass WIDTH as the bit width of the stage struct and cast in_data/out_data to and from it.
- No sub-module: storage array, pointers and counter are small enough to live inline.
- A separate counter module is not warranted.

Test Plan:
- Reset with DEPTH=2: assert nRST low mid-cycle → out_valid=0, count=0, in_ready=1, out_data=0 immediately, without waiting for a CLK edge.
- Streaming: push 0xA1, 0xA2, 0xA3 on consecutive edges with out_ready=1 → out_data 0xA1, 0xA2, 0xA3 one cycle after each push; count stays 1; in_ready stays 1.
- Backpressure/full: out_ready=0, push 0x11 and 0x22 → count=2, in_ready=0; 0x33 is held and not accepted. Raise out_ready → pops 0x11, accepts 0x33 next cycle; order out is 0x11, 0x22, 0x33.
- Simultaneous push and pop at full: count=2, in_valid=1, out_ready=1 → pop occurs, push is refused, count=1. Next cycle the push is accepted and count stays 1 with out_ready=1.
- Flush: count=2 holding 0x55, 0x66; flush=1 with in_valid=1, in_data=0x77 → next cycle count=0, out_valid=0, out_data=0; 0x77 never appears.
- Wrap-around with DEPTH=4: push 10 sequential values 0..9 with irregular out_ready (pattern 1,0,0,1,1,0,…) → output sequence 0..9 in order, pointers wrap twice, count never exceeds 4.
